riscv_test_monitor: RTL and testbench

Parametrised end-of-test monitor for the single-cycle RISC-V core, attached to the core's data-memory write port (MemWrite, DataAdr, WriteData). It replaces fixed-duration simulation runs: it counts cycles and memory writes, detects a pass/fail signature store to a configurable address, and flags a timeout. It optionally logs every store in a trace FIFO that a bench or debug port drains with a valid/ready handshake.

---
 rtl/riscv_test_monitor.sv | 175 +++++++++++++++++
 tb/tb_riscv_test_monitor.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_test_monitor.sv
// riscv_test_monitor
// End-of-test monitor attached to the data-memory write port of the
// single-cycle RISC-V core. It counts cycles and stores while the test runs
// and watches for a signature store to DONE_ADR. A value of PASS_DATA means
// pass and any other value means fail. If no signature store arrives within
// TIMEOUT_CYCLES, the test is flagged as timed out.
//
// Optional feature macro: RISCV_MON_TRACE_EN
//   When defined, every store observed in RUN is logged into a show-ahead
//   trace FIFO that is drained with a valid/ready handshake.
//   When undefined, no FIFO storage exists, the trace outputs are tied to 0
//   and trace_ready is ignored.
//
// Ports
//   clk            in   rising-edge clock
//   reset          in   asynchronous active-high reset
//   MemWrite       in   core store strobe
//   DataAdr        in   store address (XLEN)
//   WriteData      in   store data (XLEN)
//   done           out  test finished (pass, fail or timeout)
//   pass           out  signature store carried PASS_DATA
//   fail           out  signature store carried any other value
//   timeout        out  no signature store within TIMEOUT_CYCLES
//   cycle_count    out  cycles spent in RUN (frozen afterwards)
//   write_count    out  stores observed in RUN (wraps modulo 2^32)
//   trace_valid    out  trace FIFO non-empty
//   trace_adr      out  head-entry address
//   trace_data     out  head-entry data
//   trace_ready    in   consumer pops the head while trace_valid is high
//   trace_overflow out  sticky: a store was dropped on a full FIFO

module riscv_test_monitor #(
    parameter int              XLEN           = 32,
    parameter logic [XLEN-1:0] DONE_ADR       = 32'd100,
    parameter logic [XLEN-1:0] PASS_DATA      = 32'd25,
    parameter int              TIMEOUT_CYCLES = 500,
    parameter int              TRACE_DEPTH    = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            MemWrite,
    input  logic [XLEN-1:0] DataAdr,
    input  logic [XLEN-1:0] WriteData,
    output logic            done,
    output logic            pass,
    output logic            fail,
    output logic            timeout,
    output logic [31:0]     cycle_count,
    output logic [31:0]     write_count,
    output logic            trace_valid,
    output logic [XLEN-1:0] trace_adr,
    output logic [XLEN-1:0] trace_data,
    input  logic            trace_ready,
    output logic            trace_overflow
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        PASS    = 2'd1,
        FAIL    = 2'd2,
        TIMEOUT = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_cycleCount;
    logic [31:0] r_writeCount;

    logic w_running;
    logic w_doneStore;
    logic w_lastCycle;

    assign w_running   = (r_state == RUN);
    assign w_doneStore = MemWrite && (DataAdr == DONE_ADR);
    assign w_lastCycle = (r_cycleCount == 32'(TIMEOUT_CYCLES - 1));

    // Test-status FSM plus cycle/store counters. Both counters advance only
    // in RUN, so they freeze at their final values once a terminal state is
    // entered. A signature store in the last allowed cycle wins over timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= RUN;
            r_cycleCount <= 32'd0;
            r_writeCount <= 32'd0;
        end else if (w_running) begin
            r_cycleCount <= r_cycleCount + 32'd1;
            if (MemWrite) begin
                r_writeCount <= r_writeCount + 32'd1;
            end
            if (w_doneStore) begin
                r_state <= (WriteData == PASS_DATA) ? PASS : FAIL;
            end else if (w_lastCycle) begin
                r_state <= TIMEOUT;
            end
        end
    end

    // Status is decoded purely from registered state, so no combinational
    // path exists from MemWrite to any output.
    assign done        = (r_state != RUN);
    assign pass        = (r_state == PASS);
    assign fail        = (r_state == FAIL);
    assign timeout     = (r_state == TIMEOUT);
    assign cycle_count = r_cycleCount;
    assign write_count = r_writeCount;

`ifdef RISCV_MON_TRACE_EN
    localparam int AW = $clog2(TRACE_DEPTH);

    logic [XLEN-1:0] r_adrMem  [TRACE_DEPTH];
    logic [XLEN-1:0] r_dataMem [TRACE_DEPTH];
    logic [AW-1:0]   r_wrPtr;
    logic [AW-1:0]   r_rdPtr;
    logic [AW:0]     r_count;
    logic            r_overflow;

    logic w_push;
    logic w_pop;
    logic w_full;
    logic w_accept;

    assign w_push   = MemWrite && w_running;
    assign w_pop    = (r_count != '0) && trace_ready;
    assign w_full   = (r_count == (AW+1)'(TRACE_DEPTH));
    // A full FIFO still takes the push when the head leaves on the same edge.
    assign w_accept = w_push && (!w_full || w_pop);

    // Entry storage needs no reset; the occupancy counter defines validity.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_adrMem[r_wrPtr]  <= DataAdr;
            r_dataMem[r_wrPtr] <= WriteData;
        end
    end

    // Pointers wrap naturally because TRACE_DEPTH is a power of two.
    // Overflow is sticky until reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            if (w_accept && !w_pop) begin
                r_count <= r_count + (AW+1)'(1);
            end else if (!w_accept && w_pop) begin
                r_count <= r_count - (AW+1)'(1);
            end
            if (w_push && !w_accept) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign trace_valid    = (r_count != '0);
    assign trace_adr      = r_adrMem[r_rdPtr];
    assign trace_data     = r_dataMem[r_rdPtr];
    assign trace_overflow = r_overflow;
`else
    logic w_unused;

    assign w_unused       = trace_ready;
    assign trace_valid    = 1'b0;
    assign trace_adr      = '0;
    assign trace_data     = '0;
    assign trace_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_riscv_test_monitor.sv
// tb_riscv_test_monitor
// Directed bench for riscv_test_monitor built with TIMEOUT_CYCLES = 50 and
// TRACE_DEPTH = 4. Expected trace values depend on whether
// RISCV_MON_TRACE_EN is defined; without it every trace output must read 0.

module tb_riscv_test_monitor;

`ifdef RISCV_MON_TRACE_EN
    localparam bit TRACE_EN = 1'b1;
`else
    localparam bit TRACE_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic        done;
    logic        pass;
    logic        fail;
    logic        timeout;
    logic [31:0] cycle_count;
    logic [31:0] write_count;
    logic        trace_valid;
    logic [31:0] trace_adr;
    logic [31:0] trace_data;
    logic        trace_ready;
    logic        trace_overflow;

    int testCount = 0;
    int failCount = 0;

    riscv_test_monitor #(
        .XLEN(32),
        .DONE_ADR(32'd100),
        .PASS_DATA(32'd25),
        .TIMEOUT_CYCLES(50),
        .TRACE_DEPTH(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .MemWrite(MemWrite),
        .DataAdr(DataAdr),
        .WriteData(WriteData),
        .done(done),
        .pass(pass),
        .fail(fail),
        .timeout(timeout),
        .cycle_count(cycle_count),
        .write_count(write_count),
        .trace_valid(trace_valid),
        .trace_adr(trace_adr),
        .trace_data(trace_data),
        .trace_ready(trace_ready),
        .trace_overflow(trace_overflow)
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and settle 1 unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic mw, input logic [31:0] adr,
                                 input logic [31:0] data);
        MemWrite  = mw;
        DataAdr   = adr;
        WriteData = data;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reset for two edges; released 1 unit after an edge so the next edge
    // is the first edge spent in RUN.
    task automatic doReset();
        reset       = 1'b1;
        trace_ready = 1'b0;
        applyStimulus(1'b0, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        // Reset state
        doReset();
        reset = 1'b1;
        #1;
        checkOutput("reset_done", done, 0);
        checkOutput("reset_pass", pass, 0);
        checkOutput("reset_fail", fail, 0);
        checkOutput("reset_timeout", timeout, 0);
        checkOutput("reset_cycles", cycle_count, 0);
        checkOutput("reset_writes", write_count, 0);
        checkOutput("reset_tvalid", trace_valid, 0);
        checkOutput("reset_tovf", trace_overflow, 0);

        // Pass store at cycle 10
        doReset();
        repeat (10) tick();
        checkOutput("pre_pass_done", done, 0);
        applyStimulus(1'b1, 32'd100, 32'd25);
        tick();
        applyStimulus(1'b0, 32'd0, 32'd0);
        checkOutput("pass_done", done, 1);
        checkOutput("pass_pass", pass, 1);
        checkOutput("pass_fail", fail, 0);
        checkOutput("pass_timeout", timeout, 0);
        checkOutput("pass_cycles", cycle_count, 11);
        checkOutput("pass_writes", write_count, 1);
        checkOutput("pass_tvalid", trace_valid, TRACE_EN ? 1 : 0);
        checkOutput("pass_tadr", trace_adr, TRACE_EN ? 100 : 0);
        checkOutput("pass_tdata", trace_data, TRACE_EN ? 25 : 0);
        repeat (3) tick();
        checkOutput("pass_cycles_frozen", cycle_count, 11);
        checkOutput("pass_writes_frozen", write_count, 1);
        checkOutput("pass_held", pass, 1);
        trace_ready = 1'b1;
        tick();
        trace_ready = 1'b0;
        checkOutput("pass_drained", trace_valid, 0);

        // Fail store, preceded by a near-miss address that must not match
        doReset();
        applyStimulus(1'b1, 32'h8000_0064, 32'd25);
        tick();
        checkOutput("nearmiss_done", done, 0);
        checkOutput("nearmiss_writes", write_count, 1);
        applyStimulus(1'b1, 32'd100, 32'd7);
        tick();
        checkOutput("fail_fail", fail, 1);
        checkOutput("fail_pass", pass, 0);
        checkOutput("fail_done", done, 1);
        checkOutput("fail_writes", write_count, 2);
        applyStimulus(1'b1, 32'd100, 32'd25);
        tick();
        applyStimulus(1'b0, 32'd0, 32'd0);
        checkOutput("fail_held", fail, 1);
        checkOutput("fail_late_pass", pass, 0);
        checkOutput("fail_writes_frozen", write_count, 2);
        checkOutput("fail_cycles", cycle_count, 2);

        // Timeout with no stores
        doReset();
        repeat (49) tick();
        checkOutput("pre_to_timeout", timeout, 0);
        checkOutput("pre_to_cycles", cycle_count, 49);
        tick();
        checkOutput("to_timeout", timeout, 1);
        checkOutput("to_done", done, 1);
        checkOutput("to_pass", pass, 0);
        checkOutput("to_cycles", cycle_count, 50);
        repeat (2) tick();
        checkOutput("to_cycles_frozen", cycle_count, 50);

        // Pass store on the last allowed cycle beats timeout
        doReset();
        repeat (49) tick();
        applyStimulus(1'b1, 32'd100, 32'd25);
        tick();
        applyStimulus(1'b0, 32'd0, 32'd0);
        checkOutput("last_pass", pass, 1);
        checkOutput("last_timeout", timeout, 0);
        checkOutput("last_cycles", cycle_count, 50);

        // Trace order and overflow, depth 4
        doReset();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 32'(4 * i), 32'(16 + i));
            tick();
        end
        applyStimulus(1'b0, 32'd0, 32'd0);
        checkOutput("ovf_flag", trace_overflow, TRACE_EN ? 1 : 0);
        checkOutput("ovf_writes", write_count, 5);
        trace_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checkOutput("ovf_valid", trace_valid, TRACE_EN ? 1 : 0);
            checkOutput("ovf_adr", trace_adr, TRACE_EN ? 32'(4 * i) : 0);
            checkOutput("ovf_data", trace_data, TRACE_EN ? 32'(16 + i) : 0);
            tick();
        end
        trace_ready = 1'b0;
        checkOutput("ovf_empty", trace_valid, 0);
        checkOutput("ovf_sticky", trace_overflow, TRACE_EN ? 1 : 0);

        // Full FIFO with simultaneous push and pop
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'h20 + 32'(4 * i), 32'(i));
            tick();
        end
        trace_ready = 1'b1;
        applyStimulus(1'b1, 32'h30, 32'd4);
        tick();
        trace_ready = 1'b0;
        applyStimulus(1'b0, 32'd0, 32'd0);
        checkOutput("fullpp_ovf", trace_overflow, 0);
        checkOutput("fullpp_head", trace_adr, TRACE_EN ? 32'h24 : 0);
        trace_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            checkOutput("fullpp_valid", trace_valid, TRACE_EN ? 1 : 0);
            checkOutput("fullpp_adr", trace_adr, TRACE_EN ? 32'h20 + 32'(4 * i) : 0);
            checkOutput("fullpp_data", trace_data, TRACE_EN ? 32'(i) : 0);
            tick();
        end
        trace_ready = 1'b0;
        checkOutput("fullpp_empty", trace_valid, 0);

        // Asynchronous reset mid-test
        doReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h40 + 32'(4 * i), 32'(i));
            tick();
        end
        applyStimulus(1'b0, 32'd0, 32'd0);
        repeat (17) tick();
        checkOutput("mid_cycles", cycle_count, 20);
        checkOutput("mid_writes", write_count, 3);
        checkOutput("mid_tvalid", trace_valid, TRACE_EN ? 1 : 0);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_cycles", cycle_count, 0);
        checkOutput("async_writes", write_count, 0);
        checkOutput("async_tvalid", trace_valid, 0);
        checkOutput("async_done", done, 0);
        checkOutput("async_tovf", trace_overflow, 0);
        #1;
        reset = 1'b0;
        tick();
        checkOutput("restart_cycles", cycle_count, 1);
        checkOutput("restart_done", done, 0);
        checkOutput("restart_tvalid", trace_valid, 0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
